// File: rtl/raw_rgb_demosaic_pkg.sv
// Shared constants for the Bayer 2x2 binning demosaic: Bayer phase codes and FSM states.
package raw_rgb_pkg;

  localparam int BAYER_RGGB = 0;
  localparam int BAYER_GRBG = 1;
  localparam int BAYER_GBRG = 2;
  localparam int BAYER_BGGR = 3;

  typedef logic [1:0] state_t;

  localparam state_t S_SYNC   = 2'd0;
  localparam state_t S_IDLE   = 2'd1;
  localparam state_t S_ACTIVE = 2'd2;

endpackage

// File: rtl/raw_rgb_demosaic_line_buf.sv
// Single-clock line RAM for the demosaic: read-before-write, registered 1-cycle read.
module raw_line_buf #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 640,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              i_clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      r_rdata <= r_mem[i_addr];
      if (i_we) r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/raw_rgb_demosaic.sv
// Bayer-to-RGB 2x2 binning demosaic with one-line buffer, overflow flag and frame resync.
// Optional black-level subtraction stage: define RAW_RGB_BLACK_LEVEL_EN.
module raw_rgb_demosaic
  import raw_rgb_pkg::*;
#(
  parameter int IN_W        = 10,
  parameter int OUT_W       = 8,
  parameter int LINE_MAX    = 640,
  parameter int BAYER       = 0,
  parameter int BLACK_LEVEL = 0
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [IN_W-1:0]  iDATA,
  input  logic             iDVAL,
  input  logic             iLVAL,
  input  logic             iFVAL,
  output logic [OUT_W-1:0] oRed,
  output logic [OUT_W-1:0] oGreen,
  output logic [OUT_W-1:0] oBlue,
  output logic             oDVAL,
  output logic             oOVF
);

  localparam int AW = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;
  localparam int XW = $clog2(LINE_MAX + 1);
  localparam int YW = $clog2(65536);
  localparam logic [1:0]    BP     = 2'(BAYER);
  localparam logic [XW-1:0] X_FULL = XW'(LINE_MAX);

  state_t          r_state;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic            r_lval_d;
  logic            r_ovf;

  logic            w_active, w_lval_fall, w_full, w_acc, w_wr, w_out;

  assign w_active    = (r_state == S_ACTIVE);
  assign w_lval_fall = r_lval_d & ~iLVAL;
  assign w_full      = (r_x == X_FULL);
  assign w_acc       = w_active & iFVAL & iLVAL & iDVAL;
  assign w_wr        = w_acc & ~w_full;
  assign w_out       = w_wr & (r_x != '0) & (r_y != '0);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= S_SYNC;
      r_x      <= '0;
      r_y      <= '0;
      r_lval_d <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_lval_d <= iLVAL;
      case (r_state)
        S_SYNC:   if (!iFVAL) r_state <= S_IDLE;
        S_IDLE:   if (iFVAL) begin
                    r_state <= S_ACTIVE;
                    r_y     <= '0;
                    r_ovf   <= 1'b0;
                  end
        S_ACTIVE: if (!iFVAL) r_state <= S_IDLE;
        default:  r_state <= S_SYNC;
      endcase
      // X saturates at LINE_MAX; any pixel beyond that only raises the flag
      if (!w_active || !iFVAL || w_lval_fall) r_x <= '0;
      else if (w_wr)                          r_x <= r_x + XW'(1);
      if (w_active && w_lval_fall && (r_x != '0)) r_y <= r_y + YW'(1);
      if (w_acc && w_full) r_ovf <= 1'b1;
    end
  end

  logic [IN_W-1:0] w_s_px;
  logic [AW-1:0]   w_s_addr;
  logic            w_s_wr, w_s_out, w_s_cx, w_s_cy;

`ifdef RAW_RGB_BLACK_LEVEL_EN
  function automatic logic [IN_W-1:0] f_black_sub(input logic [IN_W-1:0] v);
    if (int'(v) > BLACK_LEVEL) return v - IN_W'(BLACK_LEVEL);
    return '0;
  endfunction

  logic [IN_W-1:0] r_px_pb;
  logic [AW-1:0]   r_addr_pb;
  logic            r_cx_pb, r_cy_pb;
  logic            vld_wr_pb, vld_out_pb;

  // black-level stage
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vld_wr_pb  <= 1'b0;
      vld_out_pb <= 1'b0;
    end else begin
      vld_wr_pb  <= w_wr;
      vld_out_pb <= w_out;
    end
  end

  always_ff @(posedge CLK) begin
    r_px_pb   <= f_black_sub(iDATA);
    r_addr_pb <= r_x[AW-1:0];
    r_cx_pb   <= r_x[0] ^ BP[0];
    r_cy_pb   <= r_y[0] ^ BP[1];
  end

  assign w_s_px   = r_px_pb;
  assign w_s_addr = r_addr_pb;
  assign w_s_wr   = vld_wr_pb;
  assign w_s_out  = vld_out_pb;
  assign w_s_cx   = r_cx_pb;
  assign w_s_cy   = r_cy_pb;
`else
  assign w_s_px   = iDATA;
  assign w_s_addr = r_x[AW-1:0];
  assign w_s_wr   = w_wr;
  assign w_s_out  = w_out;
  assign w_s_cx   = r_x[0] ^ BP[0];
  assign w_s_cy   = r_y[0] ^ BP[1];
`endif

  logic [IN_W-1:0] w_rd;

  raw_line_buf #(.DATA_W(IN_W), .DEPTH(LINE_MAX)) u_line_buf (
    .i_clk   (CLK),
    .i_en    (w_s_wr),
    .i_we    (w_s_wr),
    .i_addr  (w_s_addr),
    .i_wdata (w_s_px),
    .o_rdata (w_rd)
  );

  // p0: window registers alongside the RAM read (w_rd is p01)
  logic [IN_W-1:0] r_p00_p0, r_p10_p0, r_p11_p0;
  logic            r_cx_p0, r_cy_p0;
  logic            vld_p0;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) vld_p0 <= 1'b0;
    else          vld_p0 <= w_s_out;
  end

  always_ff @(posedge CLK) begin
    if (w_s_wr) begin
      r_p11_p0 <= w_s_px;
      r_p10_p0 <= r_p11_p0;
      r_p00_p0 <= w_rd;
      r_cx_p0  <= w_s_cx;
      r_cy_p0  <= w_s_cy;
    end
  end

  logic [IN_W-1:0] w_r, w_b, w_g;
  logic [IN_W:0]   w_gsum;

  always_comb begin
    w_r = r_p11_p0;
    w_b = r_p00_p0;
    case ({r_cy_p0, r_cx_p0})
      2'b00: begin w_r = r_p11_p0; w_b = r_p00_p0; end
      2'b01: begin w_r = r_p10_p0; w_b = w_rd;     end
      2'b10: begin w_r = w_rd;     w_b = r_p10_p0; end
      2'b11: begin w_r = r_p00_p0; w_b = r_p11_p0; end
      default: ;
    endcase
    // greens sit on the diagonal not occupied by R/B
    if (r_cx_p0 == r_cy_p0) w_gsum = {1'b0, w_rd} + {1'b0, r_p10_p0};
    else                    w_gsum = {1'b0, r_p00_p0} + {1'b0, r_p11_p0};
    w_g = w_gsum[IN_W:1];
  end

  // p1: output registers, held while no window completes
  logic [OUT_W-1:0] r_red_p1, r_green_p1, r_blue_p1;
  logic             vld_p1;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vld_p1     <= 1'b0;
      r_red_p1   <= '0;
      r_green_p1 <= '0;
      r_blue_p1  <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        r_red_p1   <= w_r[IN_W-1 -: OUT_W];
        r_green_p1 <= w_g[IN_W-1 -: OUT_W];
        r_blue_p1  <= w_b[IN_W-1 -: OUT_W];
      end
    end
  end

  assign oRed   = r_red_p1;
  assign oGreen = r_green_p1;
  assign oBlue  = r_blue_p1;
  assign oDVAL  = vld_p1;
  assign oOVF   = r_ovf;

endmodule
